// File: rtl/clk_ratio_meter.sv
// ---------------------------------------------------------------------------
// clk_ratio_meter
//   Measures a slow periodic signal (typically the output of an integer clock
//   divider) against the reference clock clk. Reports the rise-to-rise period
//   and the high time, both in clk cycles. Flags lock when two consecutive
//   captured periods match, and flags a stopped input when no rising edge
//   arrives before the period counter saturates.
//
// Ports
//   clk         in   1      reference clock, all logic on posedge
//   rst_n       in   1      asynchronous active-low reset
//   sig_in      in   1      measured signal, asynchronous to clk
//   clr         in   1      synchronous clear (synchroniser flops are kept)
//   period      out  WIDTH  last captured period in clk cycles
//   high_time   out  WIDTH  last captured high time in clk cycles
//   meas_valid  out  1      one-cycle pulse when period/high_time update
//   locked      out  1      last two captured periods are equal
//   stopped     out  1      no rising edge seen within the timeout
// ---------------------------------------------------------------------------
module clk_ratio_meter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stopped
);

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    // Synchroniser chain plus one delay flop for edge detection.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_d_q;
    logic                   s_d_d;
    logic                   s_s;
    logic                   rise_s;

    // Measurement state.
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] per_cnt_q;
    logic [WIDTH-1:0] per_cnt_d;
    logic [WIDTH-1:0] hi_cnt_q;
    logic [WIDTH-1:0] hi_cnt_d;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
    logic [WIDTH-1:0] high_time_q;
    logic [WIDTH-1:0] high_time_d;
    logic             meas_valid_q;
    logic             meas_valid_d;
    logic             locked_q;
    logic             locked_d;
    logic             stopped_q;
    logic             stopped_d;
    logic             have_prev_q;
    logic             have_prev_d;

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign rise_s = s_s & ~s_d_q;

    // Next value of the synchroniser chain and edge-delay flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d  = s_s;
    end

    // Synchroniser flops: cleared only by rst_n, clr leaves them running so
    // the edge detector never sees a spurious rise after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    // Next-state and next-output computation for the measurement FSM.
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stopped_d    = stopped_q;
        have_prev_d  = have_prev_q;

        if (clr) begin
            // clr beats a simultaneous rise: the edge is dropped.
            state_d     = S_WAIT;
            per_cnt_d   = CNT_ZERO;
            hi_cnt_d    = CNT_ZERO;
            period_d    = CNT_ZERO;
            high_time_d = CNT_ZERO;
            locked_d    = 1'b0;
            stopped_d   = 1'b0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    // First rise only establishes the reference edge.
                    if (rise_s) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_RUN: begin
                    if (rise_s) begin
                        period_d     = per_cnt_q;
                        high_time_d  = hi_cnt_q;
                        meas_valid_d = 1'b1;
                        // period_q still holds the previous capture here.
                        locked_d     = have_prev_q && (per_cnt_q == period_q);
                        have_prev_d  = 1'b1;
                        stopped_d    = 1'b0;
                        per_cnt_d    = CNT_ONE;
                        hi_cnt_d     = CNT_ONE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        // Saturation is the timeout, so the counters never wrap.
                        stopped_d   = 1'b1;
                        locked_d    = 1'b0;
                        have_prev_d = 1'b0;
                        state_d     = S_WAIT;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (s_s) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end else begin
                            hi_cnt_d = hi_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = S_WAIT;
                end
            endcase
        end
    end

    // Measurement FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT;
            per_cnt_q    <= CNT_ZERO;
            hi_cnt_q     <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            high_time_q  <= CNT_ZERO;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stopped_q    <= 1'b0;
            have_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stopped_q    <= stopped_d;
            have_prev_q  <= have_prev_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign stopped    = stopped_q;

endmodule
